// File: rtl/msg_schedule_if.sv
`default_nettype none
// ============================================================================
//  Module   : msg_schedule_if
//  Purpose  : Stream interface for the SHA-256 message-schedule expander.
//             Carries the block-start strobe, the 32-bit input word stream,
//             the 32-bit schedule word stream and the busy/done status.
//             Optional macro MSG_SCHED_IDX_EN adds the w_idx word index.
//  Revision : 1.0  initial release
// ============================================================================
interface msg_schedule_if;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_ready;
    logic        busy;
    logic        done;
`ifdef MSG_SCHED_IDX_EN
    logic [5:0]  w_idx;

    // Upstream/downstream side (drives block words, accepts schedule words)
    modport master (
        output start, in_valid, in_data, w_ready,
        input  in_ready, w_valid, w_data, busy, done, w_idx
    );

    // Expander side
    modport slave (
        input  start, in_valid, in_data, w_ready,
        output in_ready, w_valid, w_data, busy, done, w_idx
    );
`else
    // Upstream/downstream side (drives block words, accepts schedule words)
    modport master (
        output start, in_valid, in_data, w_ready,
        input  in_ready, w_valid, w_data, busy, done
    );

    // Expander side
    modport slave (
        input  start, in_valid, in_data, w_ready,
        output in_ready, w_valid, w_data, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/msg_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : msg_schedule
//  Purpose  : SHA-256 message-schedule expander. Takes sixteen 32-bit words
//             of one block and emits W[0..63] through a single output
//             register. W[0..15] pass through; W[16..63] come from a
//             16-word sliding window using the small-sigma functions.
//             Optional macro MSG_SCHED_IDX_EN adds the registered w_idx port.
//  Revision : 1.0  initial release
// ============================================================================

// Small sigma 0: rotr7 ^ rotr18 ^ shr3
module msg_schedule_sigma0 (
    input  wire logic [31:0] x,
    output logic      [31:0] y
);
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
endmodule

module msg_schedule (
    input  wire logic       clk,
    input  wire logic       rst_n,
    msg_schedule_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [6:0]  t;              // words loaded into the output register
    logic [31:0] win [16];       // win[0] oldest .. win[15] newest
    logic        w_valid_q;
    logic [31:0] w_data_q;
    logic        done_q;

    logic        out_free;
    logic        load_acc;
    logic        gen_fire;
    logic        last_take;
    logic [31:0] sig0_val;
    logic [31:0] sig1_val;
    logic [31:0] w_new;
    logic [31:0] push_word;

    // Small sigma 1: rotr17 ^ rotr19 ^ shr10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    msg_schedule_sigma0 u_sigma0 (
        .x (win[1]),
        .y (sig0_val)
    );

    assign sig1_val = sigma1(win[14]);
    assign w_new    = sig1_val + win[9] + sig0_val + win[0];

    // The output register can take a new word when empty or being drained
    assign out_free  = !w_valid_q || bus.w_ready;
    assign load_acc  = (state == S_LOAD) && bus.in_valid && out_free;
    // t reaching 64 means W[63] is already registered; stop generating
    assign gen_fire  = (state == S_EXPAND) && out_free && !t[6];
    assign last_take = (state == S_EXPAND) && t[6] && w_valid_q && bus.w_ready;
    assign push_word = load_acc ? bus.in_data : w_new;

    assign bus.in_ready = (state == S_LOAD) && out_free;
    assign bus.w_valid  = w_valid_q;
    assign bus.w_data   = w_data_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_acc && (t == 7'd15)) begin
                    state_nx = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (last_take) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output register, sliding window and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t         <= 7'd0;
            w_valid_q <= 1'b0;
            w_data_q  <= 32'd0;
            done_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else begin
            done_q <= last_take;
            if ((state == S_IDLE) && bus.start) begin
                t <= 7'd0;
            end
            if (load_acc || gen_fire) begin
                w_data_q  <= push_word;
                w_valid_q <= 1'b1;
                t         <= t + 7'd1;
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i + 1];
                end
                win[15] <= push_word;
            end else if (bus.w_ready) begin
                w_valid_q <= 1'b0;
            end
        end
    end

`ifdef MSG_SCHED_IDX_EN
    logic [5:0] idx_q;

    // Index of the word currently held in the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 6'd0;
        end else if (load_acc || gen_fire) begin
            idx_q <= t[5:0];
        end
    end

    assign bus.w_idx = idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msg_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msg_schedule
//  Purpose  : Self-checking bench for msg_schedule using the "abc" block,
//             a table of stream scenarios and a table of hand-computed words.
//             Honours MSG_SCHED_IDX_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_msg_schedule;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    msg_schedule_if bus ();

    msg_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int stall_idx;   // output word index held off by w_ready=0
        int stall_len;
        int gap_cnt;     // input count after which in_valid drops
        int gap_len;
        int start_at;    // output index at which a stray start is pulsed
        int abort_at;    // output index at which reset is asserted
        int exp_done;    // cycles from first input acceptance to done
    } scen_t;

    typedef struct {
        int          idx;
        logic [31:0] w;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cur_scen = 0;
    logic [31:0] blk   [16];
    logic [31:0] ref_w [64];
    logic [31:0] got   [64];
    scen_t       scen  [7];
    vec_t        vecs  [6];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (scenario %0d): got %h want %h", name, cur_scen, act, exp);
        end
    endtask

    task automatic run_block(input scen_t s, input int sn);
        int          in_cnt;
        int          out_cnt;
        int          cyc;
        int          c0;
        int          done_cyc;
        int          done_cnt;
        int          stall_left;
        int          gap_left;
        int          stall_seen;
        int          first_out;
        int          last_out;
        int          valid_cycles;
        bit          finished;
        bit          aborted;
        bit          start_sent;
        logic [31:0] stall_data;

        cur_scen     = sn;
        in_cnt       = 0;
        out_cnt      = 0;
        cyc          = 0;
        c0           = -1;
        done_cyc     = -1;
        done_cnt     = 0;
        stall_left   = s.stall_len;
        gap_left     = s.gap_len;
        stall_seen   = 0;
        first_out    = -1;
        last_out     = -1;
        valid_cycles = 0;
        finished     = 1'b0;
        aborted      = 1'b0;
        start_sent   = 1'b0;
        stall_data   = 32'd0;
        for (int i = 0; i < 64; i++) got[i] = 32'hDEAD_BEEF;

        while (!finished && cyc < 300) begin
            // drive (posedge + 1)
            bus.start = (cyc == 0);
            if (s.start_at >= 0 && !start_sent && out_cnt == s.start_at) begin
                bus.start  = 1'b1;
                start_sent = 1'b1;
            end
            if (in_cnt < 16) begin
                if (in_cnt == s.gap_cnt && gap_left > 0) begin
                    bus.in_valid = 1'b0;
                    gap_left--;
                end else begin
                    bus.in_valid = 1'b1;
                end
                bus.in_data = blk[in_cnt];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 32'd0;
            end
            if (bus.w_valid && out_cnt == s.stall_idx && stall_left > 0) begin
                bus.w_ready = 1'b0;
                stall_left--;
            end else begin
                bus.w_ready = 1'b1;
            end
            #1;
            if (s.abort_at >= 0 && out_cnt == s.abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_w_valid",  {31'd0, bus.w_valid},  32'd0);
                chk("abort_w_data",   bus.w_data,            32'd0);
                chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
                chk("abort_busy",     {31'd0, bus.busy},     32'd0);
                chk("abort_done",     {31'd0, bus.done},     32'd0);
                aborted  = 1'b1;
                finished = 1'b1;
            end else begin
                // sample (posedge + 2)
                if (bus.done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                    finished = 1'b1;
                end
                if (bus.w_valid) valid_cycles++;
                if (bus.w_valid && !bus.w_ready) begin
                    if (stall_seen == 0) stall_data = bus.w_data;
                    else chk("stall_hold", bus.w_data, stall_data);
                    stall_seen++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    if (c0 < 0) c0 = cyc;
                    in_cnt++;
                end
                if (bus.w_valid && bus.w_ready) begin
                    if (out_cnt < 64) begin
                        got[out_cnt] = bus.w_data;
                        chk($sformatf("w_data[%0d]", out_cnt), bus.w_data, ref_w[out_cnt]);
`ifdef MSG_SCHED_IDX_EN
                        chk("w_idx", {26'd0, bus.w_idx}, 32'(out_cnt));
`endif
                    end
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    out_cnt++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end

        if (aborted) begin
            chk("abort_hold_valid", {31'd0, bus.w_valid}, 32'd0);
            chk("abort_no_done",    {31'd0, bus.done},    32'd0);
            chk("abort_done_count", 32'(done_cnt),        32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end else if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout (scenario %0d): got no done after %0d cycles want done", sn, cyc);
        end else begin
            chk("done_width",   {31'd0, bus.done},    32'd0);
            chk("in_count",     32'(in_cnt),          32'd16);
            chk("out_count",    32'(out_cnt),         32'd64);
            chk("done_count",   32'(done_cnt),        32'd1);
            chk("done_latency", 32'(done_cyc - c0),   32'(s.exp_done));
            chk("out_span",     32'(last_out - first_out), 32'(63 + s.stall_len + s.gap_len));
            chk("valid_cycles", 32'(valid_cycles),    32'(64 + s.stall_len));
            chk("stall_cycles", 32'(stall_seen),      32'(s.stall_len));
        end
    endtask

    task automatic check_vecs();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hand_W%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].w);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // "abc" block after padding
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;

        // reference schedule from the standard recurrence
        for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            ref_w[i] = ssig1(ref_w[i-2]) + ref_w[i-7] + ssig0(ref_w[i-15]) + ref_w[i-16];
        end

        vecs[0] = '{0,  32'h6162_6380};
        vecs[1] = '{1,  32'h0000_0000};
        vecs[2] = '{15, 32'h0000_0018};
        vecs[3] = '{16, 32'h6162_6380};
        vecs[4] = '{17, 32'h000F_0000};
        vecs[5] = '{63, 32'h12B1_EDEB};

        //          stall_idx len gap_cnt len start_at abort_at exp_done
        scen[0] = '{-1, 0, -1, 0, -1, -1, 65};   // plain
        scen[1] = '{20, 5, -1, 0, -1, -1, 70};   // output backpressure on W[20]
        scen[2] = '{-1, 0,  5, 3, -1, -1, 68};   // input gap between W4 and W5
        scen[3] = '{-1, 0, -1, 0, 30, -1, 65};   // stray start while busy
        scen[4] = '{-1, 0, -1, 0, -1, 40,  0};   // reset mid-EXPAND
        scen[5] = '{-1, 0, -1, 0, -1, -1, 65};   // recovery after reset
        scen[6] = '{-1, 0, -1, 0, -1, -1, 65};   // back-to-back block

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.w_ready  = 1'b0;

        #2;
        chk("reset_w_valid",  {31'd0, bus.w_valid},  32'd0);
        chk("reset_w_data",   bus.w_data,            32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset_busy",     {31'd0, bus.busy},     32'd0);
        chk("reset_done",     {31'd0, bus.done},     32'd0);
`ifdef MSG_SCHED_IDX_EN
        chk("reset_w_idx",    {26'd0, bus.w_idx},    32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) begin
            run_block(scen[k], k);
            if (k == 0 || k == 5 || k == 6) check_vecs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
